// File: rtl/light_ctrl_pkg.sv
// Shared types and colour codes for the intersection light controllers.
// FLASH exists only when LIGHT_CTRL_FLASH_EN is defined.
package light_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED
`ifdef LIGHT_CTRL_FLASH_EN
    , ST_FLASH
`endif
  } light_state_t;

  localparam logic [1:0] LC_RED    = 2'd0;
  localparam logic [1:0] LC_YELLOW = 2'd1;
  localparam logic [1:0] LC_DARK   = 2'd2;
  localparam logic [1:0] LC_GREEN  = 2'd3;

endpackage

// File: rtl/multi_light_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last+1, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);
  localparam int unsigned NU = N;

  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NU; k++) begin
      int unsigned j;
      j = (k + 32'(last)) % NU;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/multi_light_controller.sv
// N-approach round-robin intersection controller with bounded green and timed clearance.
// Optional flashing mode is compiled in with LIGHT_CTRL_FLASH_EN.
module multi_light_controller
  import light_ctrl_pkg::*;
#(
  parameter int NUM_APPROACHES = 4,
  parameter int CNT_W          = 8,
  parameter int MIN_GREEN      = 8,
  parameter int MAX_GREEN      = 32,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 2
`ifdef LIGHT_CTRL_FLASH_EN
  , parameter int FLASH_HALF   = 4
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_APPROACHES-1:0]         car_has_arrived,
  input  logic                              street_light_controller,
  output logic [2*NUM_APPROACHES-1:0]       set_light_color,
  output logic [$clog2(NUM_APPROACHES)-1:0] active_approach,
  output logic                              phase_busy
`ifdef LIGHT_CTRL_FLASH_EN
  , input  logic                            flash_mode
`endif
);

  localparam int IW = $clog2(NUM_APPROACHES);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
`ifdef LIGHT_CTRL_FLASH_EN
  localparam logic [CNT_W-1:0] FL_HALF  = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(2 * FLASH_HALF - 1);
`endif

  light_state_t                  state, state_next;
  logic [CNT_W-1:0]              cnt, cnt_next;
  logic [IW-1:0]                 last, last_next, active_next, win_idx;
  logic [NUM_APPROACHES-1:0]     pending, pending_next, req, grant, act_mask;
  logic [2*NUM_APPROACHES-1:0]   color_next;
  logic                          busy_next, grant_go, flash;

`ifdef LIGHT_CTRL_FLASH_EN
  assign flash = flash_mode;
`else
  assign flash = 1'b0;
`endif

  assign req = (pending | car_has_arrived) & {NUM_APPROACHES{street_light_controller}};

  rr_arbiter #(.N(NUM_APPROACHES)) u_arb (
    .req   (req),
    .last  (last),
    .grant (grant),
    .index (win_idx)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    last_next   = last;
    active_next = active_approach;
    grant_go    = 1'b0;
    act_mask    = '0;
    act_mask[active_approach] = 1'b1;
    // The green approach's own arrivals are presence, not a new request.
    pending_next = pending | car_has_arrived;
    if (state == ST_GREEN) pending_next = pending_next & ~act_mask;

    case (state)
      ST_IDLE: begin
        if (flash) begin
`ifdef LIGHT_CTRL_FLASH_EN
          state_next = ST_FLASH;
          cnt_next   = '0;
`endif
        end else if (|req) begin
          grant_go = 1'b1;
        end
      end
      ST_GREEN: begin
        if (!street_light_controller || flash ||
            (cnt >= MIN_LAST && |(req & ~act_mask) &&
             (!car_has_arrived[active_approach] || cnt == MAX_LAST))) begin
          state_next = ST_YELLOW;
          cnt_next   = '0;
        end else if (cnt != MAX_LAST) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (cnt == YEL_LAST) begin
          state_next = ST_ALL_RED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_ALL_RED: begin
        if (cnt != AR_LAST) begin
          cnt_next = cnt + CNT_W'(1);
        end else if (flash) begin
`ifdef LIGHT_CTRL_FLASH_EN
          state_next = ST_FLASH;
          cnt_next   = '0;
`endif
        end else if (|req) begin
          grant_go = 1'b1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
`ifdef LIGHT_CTRL_FLASH_EN
      ST_FLASH: begin
        if (!flash) begin
          state_next = ST_ALL_RED;
          cnt_next   = '0;
        end else begin
          cnt_next = (cnt == FL_LAST) ? '0 : cnt + CNT_W'(1);
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase

    if (grant_go) begin
      state_next   = ST_GREEN;
      cnt_next     = '0;
      active_next  = win_idx;
      last_next    = win_idx;
      pending_next = pending_next & ~grant;
    end

    // Lamps are derived from the next state so they leave the register with it.
    color_next = '0;
    for (int unsigned i = 0; i < NUM_APPROACHES; i++) begin
      color_next[2*i +: 2] = LC_RED;
      if (IW'(i) == active_next && state_next == ST_GREEN)  color_next[2*i +: 2] = LC_GREEN;
      if (IW'(i) == active_next && state_next == ST_YELLOW) color_next[2*i +: 2] = LC_YELLOW;
`ifdef LIGHT_CTRL_FLASH_EN
      if (state_next == ST_FLASH) color_next[2*i +: 2] = (cnt_next < FL_HALF) ? LC_YELLOW : LC_DARK;
`endif
    end
    busy_next = (state_next == ST_GREEN) || (state_next == ST_YELLOW) || (state_next == ST_ALL_RED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      last            <= IW'(NUM_APPROACHES - 1);
      pending         <= '0;
      active_approach <= '0;
      set_light_color <= '0;
      phase_busy      <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      last            <= last_next;
      pending         <= pending_next;
      active_approach <= active_next;
      set_light_color <= color_next;
      phase_busy      <= busy_next;
    end
  end

endmodule
